// File: rtl/chip8_pkg.sv
// Shared constants and elaboration helpers for the CHIP-8 timer subsystem.
package chip8_pkg;

    localparam int CHIP8_CLK_HZ  = 50_000_000;
    localparam int CHIP8_TICK_HZ = 60;

    // Channel indices as seen by the CPU timer instructions.
    localparam int TMR_DELAY = 0;
    localparam int TMR_SOUND = 1;

    // Clocks per tick; the fractional remainder is deliberately dropped.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Select width, kept at least one bit so a single-channel build still has a port.
    function automatic int calc_selw(input int num_ch);
        return ($clog2(num_ch) < 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/chip8_prescaler.sv
// Divide-by-DIV prescaler: strobe is high for one clock every DIV enabled clocks.
module chip8_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic strobe
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    assign strobe = en && (pre == LAST);

    // Phase counter; holds while disabled so a pause keeps the remaining phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (en) begin
            if (pre == LAST) begin
                pre <= '0;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_timer_bank.sv
// Multi-channel CHIP-8 timer bank: common tick prescaler, writable saturating
// down-counters, per-channel expiry pulses and a tick-derived heartbeat.
module chip8_timer_bank
    import chip8_pkg::*;
#(
    parameter int CLK_HZ      = CHIP8_CLK_HZ,
    parameter int TICK_HZ     = CHIP8_TICK_HZ,
    parameter int NUM_CH      = 2,
    parameter int WIDTH       = 8,
    parameter int BLINK_TICKS = 30,
    localparam int DIV        = calc_div(CLK_HZ, TICK_HZ),
    localparam int SELW       = calc_selw(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              wr_en,
    input  logic [SELW-1:0]   wr_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [SELW-1:0]   rd_sel,
    output logic [WIDTH-1:0]  rd_data,
    output logic              tick,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] expired,
    output logic              heartbeat
);

    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("chip8_timer_bank: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("chip8_timer_bank: NUM_CH must be at least 1");
    end
    if (BLINK_TICKS < 1) begin : g_bad_blink
        $error("chip8_timer_bank: BLINK_TICKS must be at least 1");
    end

    logic                s;
    logic [WIDTH-1:0]    value [NUM_CH];
    logic [NUM_CH-1:0]   wr_hit;
    logic [BW-1:0]       blink_cnt;

    chip8_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (!pause),
        .strobe (s)
    );

    // Per-channel write decode; out-of-range selects hit nothing.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_en && (wr_sel == SELW'(i));
        end
    end

    // Read mux and activity flags straight from the value registers.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active[i] = (value[i] != '0);
            if (rd_sel == SELW'(i)) begin
                rd_data = value[i];
            end
        end
    end

    // Channel values: a write wins over the tick decrement, and zero is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                value[i] <= '0;
            end
            expired <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    value[i] <= wr_data;
                end else if (s && (value[i] != '0)) begin
                    value[i] <= value[i] - 1'b1;
                end
                expired[i] <= s && (value[i] == WIDTH'(1)) && !wr_hit[i];
            end
        end
    end

    // Tick pulse lines up with the cycle that already shows decremented values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick <= 1'b0;
        end else begin
            tick <= s;
        end
    end

    // Heartbeat toggles once per BLINK_TICKS ticks; pause freezes it through s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            heartbeat <= 1'b0;
        end else if (s) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                heartbeat <= !heartbeat;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chip8_timer_bank.sv
// Directed bench for chip8_timer_bank with DIV = 10 and BLINK_TICKS = 2.
// A second instance with three channels exercises out-of-range selects.
module tb_chip8_timer_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pause = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_sel = '0;
    logic [7:0] wr_data = '0;
    logic [0:0] rd_sel = '0;
    logic [7:0] rd_data;
    logic       tick;
    logic [1:0] active;
    logic [1:0] expired;
    logic       heartbeat;

    logic       w3_en = 1'b0;
    logic [1:0] w3_sel = '0;
    logic [7:0] w3_data = '0;
    logic [1:0] r3_sel = '0;
    logic [7:0] r3_data;
    logic       tick3;
    logic [2:0] active3;
    logic [2:0] expired3;
    logic       heartbeat3;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    chip8_timer_bank #(
        .CLK_HZ(10), .TICK_HZ(1), .NUM_CH(2), .WIDTH(8), .BLINK_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .tick(tick), .active(active), .expired(expired), .heartbeat(heartbeat)
    );

    chip8_timer_bank #(
        .CLK_HZ(10), .TICK_HZ(1), .NUM_CH(3), .WIDTH(8), .BLINK_TICKS(2)
    ) dut3 (
        .clk(clk), .reset(reset), .pause(1'b0),
        .wr_en(w3_en), .wr_sel(w3_sel), .wr_data(w3_data),
        .rd_sel(r3_sel), .rd_data(r3_data),
        .tick(tick3), .active(active3), .expired(expired3), .heartbeat(heartbeat3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock; sample point is 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    // Value is captured by the next edge; returns just after that edge.
    task automatic wr(input logic [0:0] sel, input logic [7:0] data);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [0:0] sel, input logic [7:0] exp);
        rd_sel = sel;
        #1;
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_sel = 1'b0;
    endtask

    // Reset pulse that releases right after an edge, so the next edge is edge 1.
    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rd", rd_data, 0);
        chk("rst_tick", tick, 0);
        chk("rst_active", active, 0);
        chk("rst_hb", heartbeat, 0);
        chk("rst_exp", expired, 0);

        // 1: idle, tick every 10 clocks, heartbeat after second tick
        do_reset();
        for (int k = 1; k <= 35; k++) begin
            step();
            chk("t1_tick", tick, (cyc % 10 == 0) ? 1 : 0);
            chk("t1_hb", heartbeat, (cyc >= 20) ? 1 : 0);
            chk("t1_rd", rd_data, 0);
            chk("t1_active", active, 0);
            chk("t1_exp", expired, 0);
        end

        // 2: ch0 = 3 counts down over three ticks and expires once
        do_reset();
        step();
        wr(1'b0, 8'd3);
        rd_chk("t2_rd_wr", 1'b0, 8'd3);
        chk("t2_act_wr", active, 2'b01);
        run_to(10);
        rd_chk("t2_rd_t1", 1'b0, 8'd2);
        chk("t2_tick_t1", tick, 1);
        run_to(11);
        chk("t2_tick_off", tick, 0);
        chk("t2_exp_11", expired, 2'b00);
        run_to(20);
        rd_chk("t2_rd_t2", 1'b0, 8'd1);
        chk("t2_exp_20", expired, 2'b00);
        run_to(29);
        chk("t2_act_29", active, 2'b01);
        run_to(30);
        rd_chk("t2_rd_t3", 1'b0, 8'd0);
        chk("t2_exp_30", expired, 2'b01);
        chk("t2_act_30", active, 2'b00);
        run_to(31);
        chk("t2_exp_31", expired, 2'b00);
        run_to(40);
        chk("t2_exp_40", expired, 2'b00);
        rd_chk("t2_rd_40", 1'b0, 8'd0);

        // 3: two independent channels, 255 decrements to 254
        do_reset();
        wr(1'b1, 8'd200);
        wr(1'b0, 8'd2);
        chk("t3_act_2", active, 2'b11);
        run_to(10);
        rd_chk("t3_ch0_10", 1'b0, 8'd1);
        rd_chk("t3_ch1_10", 1'b1, 8'd199);
        chk("t3_act_10", active, 2'b11);
        chk("t3_exp_10", expired, 2'b00);
        run_to(20);
        rd_chk("t3_ch0_20", 1'b0, 8'd0);
        rd_chk("t3_ch1_20", 1'b1, 8'd198);
        chk("t3_act_20", active, 2'b10);
        chk("t3_exp_20", expired, 2'b01);
        wr(1'b1, 8'd255);
        rd_chk("t3_ch1_21", 1'b1, 8'd255);
        run_to(30);
        rd_chk("t3_ch1_30", 1'b1, 8'd254);
        chk("t3_exp_30", expired, 2'b00);

        // 4: write colliding with the final decrement suppresses expiry
        do_reset();
        wr(1'b0, 8'd1);
        run_to(9);
        wr(1'b0, 8'd7);
        rd_chk("t4_rd_7", 1'b0, 8'd7);
        chk("t4_exp_7", expired, 2'b00);
        chk("t4_tick_7", tick, 1);
        wr(1'b0, 8'd1);
        rd_chk("t4_rd_1", 1'b0, 8'd1);
        run_to(19);
        wr(1'b0, 8'd0);
        rd_chk("t4_rd_0", 1'b0, 8'd0);
        chk("t4_exp_0", expired, 2'b00);
        chk("t4_tick_0", tick, 1);
        step();
        chk("t4_exp_21", expired, 2'b00);
        run_to(30);
        chk("t4_tick_30", tick, 1);
        chk("t4_exp_30", expired, 2'b00);
        rd_chk("t4_rd_30", 1'b0, 8'd0);

        // 5: pause for 25 clocks with ch0 = 4, prescaler phase preserved
        do_reset();
        wr(1'b0, 8'd4);
        run_to(5);
        pause = 1'b1;
        for (int k = 6; k <= 11; k++) begin
            step();
            chk("t5_tick_p", tick, 0);
            chk("t5_rd_p", rd_data, 4);
        end
        wr(1'b1, 8'd9);
        rd_chk("t5_ch1_wr", 1'b1, 8'd9);
        for (int k = 13; k <= 30; k++) begin
            step();
            chk("t5_tick_p", tick, 0);
            chk("t5_rd_p", rd_data, 4);
            chk("t5_hb_p", heartbeat, 0);
        end
        pause = 1'b0;
        run_to(34);
        chk("t5_tick_34", tick, 0);
        rd_chk("t5_rd_34", 1'b0, 8'd4);
        run_to(35);
        chk("t5_tick_35", tick, 1);
        rd_chk("t5_rd_35", 1'b0, 8'd3);
        rd_chk("t5_ch1_35", 1'b1, 8'd8);

        // 6a: asynchronous reset clears outputs without a clock edge
        do_reset();
        wr(1'b0, 8'd9);
        wr(1'b1, 8'd2);
        run_to(20);
        chk("t6_hb_pre", heartbeat, 1);
        chk("t6_exp_pre", expired, 2'b10);
        chk("t6_tick_pre", tick, 1);
        rd_chk("t6_rd_pre", 1'b0, 8'd7);
        #1 reset = 1'b1;
        #1;
        chk("t6_clk_high", clk, 1);
        chk("t6_rd_async", rd_data, 0);
        chk("t6_hb_async", heartbeat, 0);
        chk("t6_tick_async", tick, 0);
        chk("t6_exp_async", expired, 2'b00);
        chk("t6_act_async", active, 2'b00);

        // 6b: three-channel build, select 3 is out of range
        do_reset();
        w3_en = 1'b1;
        w3_sel = 2'd3;
        w3_data = 8'h55;
        step();
        w3_en = 1'b0;
        chk("t6_act3_ign", active3, 3'b000);
        for (int k = 0; k < 4; k++) begin
            r3_sel = 2'(k);
            #1;
            chk("t6_rd3_ign", r3_data, 0);
        end
        w3_en = 1'b1;
        w3_sel = 2'd2;
        w3_data = 8'h42;
        step();
        w3_en = 1'b0;
        r3_sel = 2'd2;
        #1;
        chk("t6_rd3_ch2", r3_data, 8'h42);
        chk("t6_act3_ch2", active3, 3'b100);
        r3_sel = 2'd3;
        #1;
        chk("t6_rd3_sel3", r3_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
